frame_buffer_arbiter: RTL and testbench

- Shares the single-port frame BRAM (DEPTH words) between the deserializer (write requester) and the serializer (read requester).
- Owns independent write and read address pointers, each wrapping at DEPTH-1.
- Tracks occupancy so the serializer never reads unwritten words and the deserializer never overwrites unread ones.
- Runs on the 100 MHz system clock; requesters are slow (1 MHz-domain logic already synchronised to clock) and use a req/ack handshake.

---
 rtl/frame_buf_pkg.sv | 21 ++
 rtl/wrap_ptr.sv | 50 +++++
 rtl/frame_buffer_arbiter.sv | 172 +++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// ---------------------------------------------------------------------------
// frame_buf_pkg
// Shared types and default geometry for the frame buffer arbiter.
//   grant_state_e : arbitration state, i.e. the grant being issued this cycle
//   FRAME_DEPTH   : number of words in the frame BRAM
//   FRAME_ADDR_W  : BRAM address width
//   PIX_W         : BRAM word width
// ---------------------------------------------------------------------------
package frame_buf_pkg;

    localparam int FRAME_DEPTH  = 62500;
    localparam int FRAME_ADDR_W = 16;
    localparam int PIX_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        GNT_WR,
        GNT_RD
    } grant_state_e;

endpackage

// File: rtl/wrap_ptr.sv
// ---------------------------------------------------------------------------
// wrap_ptr
// Address pointer that counts 0..DEPTH-1 and wraps back to 0.
//   clock_i : system clock
//   reset_i : synchronous active-high reset, pointer returns to 0
//   inc_i   : advance the pointer at this edge
//   ptr_o   : current pointer value
//   wrap_o  : one-cycle pulse in the cycle after an advance from DEPTH-1 to 0
// ---------------------------------------------------------------------------
module wrap_ptr #(
    parameter int DEPTH  = 62500,
    parameter int ADDR_W = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              wrap_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_q, wrap_d;
    logic              at_last;

    always_comb begin
        at_last = (ptr_q == LAST);
        ptr_d   = ptr_q;
        wrap_d  = 1'b0;
        if (inc_i) begin
            ptr_d  = at_last ? '0 : ptr_q + ADDR_W'(1);
            wrap_d = at_last;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
// Shares a single-port frame BRAM between a write requester (deserializer)
// and a read requester (serializer). One grant per cycle, round-robin on
// conflict, occupancy tracking so neither side overruns the other.
//   clock, reset       : system clock, synchronous active-high reset
//   enable             : low blocks new grants; in-flight reads still return
//   wr_req/wr_data     : write request level and data; wr_ack pulses on issue
//   rd_req             : read request level; rd_ack pulses on issue
//   rd_data/rd_valid   : returned read word, rd_valid pulses RD_LAT after ack
//   mem_addr/we/din    : registered BRAM controls; mem_dout is BRAM read data
//   full/empty         : occupancy flags from the registered count
//   wr_wrap/rd_wrap    : pulse alongside the ack that wraps the pointer
// ---------------------------------------------------------------------------
module frame_buffer_arbiter
    import frame_buf_pkg::*;
#(
    parameter int DEPTH  = FRAME_DEPTH,
    parameter int ADDR_W = FRAME_ADDR_W,
    parameter int DATA_W = PIX_W,
    parameter int CNT_W  = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              full,
    output logic              empty,
    output logic              wr_wrap,
    output logic              rd_wrap
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    grant_state_e      state_q, state_d;
    logic              last_rd_q, last_rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [RD_LAT:0]   rd_taps;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_elig, rd_elig;
    logic              grant_wr, grant_rd;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // The count only moves at the end of an ack cycle, so a grant already in
    // its ack cycle is not yet reflected in full/empty. Block the one extra
    // grant that would otherwise overflow or underflow the buffer.
    always_comb begin
        wr_elig = enable & wr_req & ~full
                & ~((state_q == GNT_WR) && (count_q == CNT_LAST));
        rd_elig = enable & rd_req & ~empty
                & ~((state_q == GNT_RD) && (count_q == CNT_ONE));
    end

    // last_rd_q only changes on a true conflict; a lone requester does not
    // steal the other side's turn.
    always_comb begin
        state_d   = IDLE;
        last_rd_d = last_rd_q;
        if (wr_elig && rd_elig) begin
            if (last_rd_q) begin
                state_d   = GNT_WR;
                last_rd_d = 1'b0;
            end else begin
                state_d   = GNT_RD;
                last_rd_d = 1'b1;
            end
        end else if (wr_elig) begin
            state_d = GNT_WR;
        end else if (rd_elig) begin
            state_d = GNT_RD;
        end
    end

    assign grant_wr = (state_d == GNT_WR);
    assign grant_rd = (state_d == GNT_RD);

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (grant_wr) begin
            mem_addr_d = wr_ptr;
            mem_din_d  = wr_data;
        end else if (grant_rd) begin
            mem_addr_d = rd_ptr;
        end
        count_d = count_q;
        case (state_q)
            GNT_WR:  count_d = count_q + CNT_ONE;
            GNT_RD:  count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Tap 0 is the ack cycle itself; mem_dout is captured at the edge that
    // ends tap RD_LAT-1, and rd_valid is the last tap.
    assign rd_taps = {rd_pipe_q, rd_ack};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            last_rd_q  <= 1'b1;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            rd_pipe_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= grant_wr;
            mem_din_q  <= mem_din_d;
            rd_pipe_q  <= rd_taps[RD_LAT-1:0];
            if (rd_taps[RD_LAT-1]) begin
                rd_data_q <= mem_dout;
            end
        end
    end

    wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clock_i (clock),
        .reset_i (reset),
        .inc_i   (grant_wr),
        .ptr_o   (wr_ptr),
        .wrap_o  (wr_wrap)
    );

    wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clock_i (clock),
        .reset_i (reset),
        .inc_i   (grant_rd),
        .ptr_o   (rd_ptr),
        .wrap_o  (rd_wrap)
    );

    assign wr_ack   = (state_q == GNT_WR);
    assign rd_ack   = (state_q == GNT_RD);
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_din  = mem_din_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_taps[RD_LAT];

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_arbiter
// Directed bench for frame_buffer_arbiter with a behavioural BRAM whose read
// data follows the registered address. A reduced DEPTH keeps the wrap and
// full cases short.
// ---------------------------------------------------------------------------
module tb_frame_buffer_arbiter;

    localparam int TB_DEPTH = 40;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 17;
    localparam int RD_LAT   = 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              full;
    logic              empty;
    logic              wr_wrap;
    logic              rd_wrap;

    logic [DATA_W-1:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_din;
    end
    assign mem_dout = mem[mem_addr[5:0]];

    frame_buffer_arbiter #(
        .DEPTH  (TB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .full     (full),
        .empty    (empty),
        .wr_wrap  (wr_wrap),
        .rd_wrap  (rd_wrap)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        enable = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp3 [0:2];
        logic [7:0] exp_prev;
        logic       prev_ack;
        logic       got;
        logic       wrap_seen;
        int         k, v, n, acks, rd_idx;
        logic [ADDR_W-1:0] last_addr;

        reset   = 1'b1;
        enable  = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = '0;
        step(); step(); step();

        // reset state
        check_val("rst_wr_ack",   32'(wr_ack),   32'd0);
        check_val("rst_rd_ack",   32'(rd_ack),   32'd0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst_mem_we",   32'(mem_we),   32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_din",  32'(mem_din),  32'd0);
        check_val("rst_rd_data",  32'(rd_data),  32'd0);
        check_val("rst_empty",    32'(empty),    32'd1);
        check_val("rst_full",     32'(full),     32'd0);
        check_val("rst_wraps",    32'({wr_wrap, rd_wrap}), 32'd0);
        reset = 1'b0;

        // sustained write of 0x00..0x04
        wr_req  = 1'b1;
        wr_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t1_wr_ack",   32'(wr_ack),   32'd1);
            check_val("t1_mem_we",   32'(mem_we),   32'd1);
            check_val("t1_mem_addr", 32'(mem_addr), 32'(i));
            check_val("t1_mem_din",  32'(mem_din),  32'(i));
            check_val("t1_empty",    32'(empty),    32'(i == 0));
            wr_data = 8'(i + 1);
            if (i == 4) wr_req = 1'b0;
        end
        step();
        check_val("t1_idle_ack",  32'(wr_ack),   32'd0);
        check_val("t1_idle_we",   32'(mem_we),   32'd0);
        check_val("t1_idle_addr", 32'(mem_addr), 32'd4);
        // drain: exactly five words are readable
        rd_req = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n += int'(rd_ack);
        end
        rd_req = 1'b0;
        check_val("t1_drain_cnt",  32'(n),       32'd5);
        check_val("t1_drain_emp",  32'(empty),   32'd1);
        check_val("t1_drain_last", 32'(rd_data), 32'h04);

        // three writes then a held read
        do_reset();
        exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;
        wr_req  = 1'b1;
        wr_data = exp3[0];
        step(); wr_data = exp3[1];
        step(); wr_data = exp3[2];
        step();
        wr_req = 1'b0;
        rd_req = 1'b1;
        k = 0; v = 0; prev_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("t2_valid_lat", 32'(rd_valid), 32'(prev_ack));
            if (rd_valid && v < 3) begin
                check_val("t2_rd_data", 32'(rd_data), 32'(exp3[v]));
                v++;
            end
            if (rd_ack) begin
                check_val("t2_rd_addr", 32'(mem_addr), 32'(k));
                check_val("t2_rd_we",   32'(mem_we),   32'd0);
                k++;
            end
            prev_ack = rd_ack;
        end
        rd_req = 1'b0;
        check_val("t2_ack_cnt",   32'(k),     32'd3);
        check_val("t2_valid_cnt", 32'(v),     32'd3);
        check_val("t2_empty",     32'(empty), 32'd1);
        step();
        check_val("t2_data_hold", 32'(rd_data), 32'hC3);

        // alternation with count = 10
        do_reset();
        wr_req  = 1'b1;
        wr_data = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            wr_data = 8'(i + 1);
        end
        wr_req = 1'b0;
        step(); step();
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 8'h77;
        rd_idx  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("t3_wr_ack", 32'(wr_ack), 32'(i % 2 == 0));
            check_val("t3_rd_ack", 32'(rd_ack), 32'(i % 2 == 1));
            if (rd_valid) begin
                check_val("t3_rd_data", 32'(rd_data), 32'(rd_idx));
                rd_idx++;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        check_val("t3_full",  32'(full),  32'd0);
        check_val("t3_empty", 32'(empty), 32'd0);
        check_val("t3_rd_cnt", 32'(rd_idx), 32'd3);

        // fill to full with write-pointer wrap
        do_reset();
        wr_req  = 1'b1;
        wr_data = 8'd0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            step();
            check_val("t4_fill_ack", 32'(wr_ack),  32'd1);
            check_val("t4_wr_wrap",  32'(wr_wrap), 32'(i == TB_DEPTH - 1));
            if (i == TB_DEPTH - 1)
                check_val("t4_last_addr", 32'(mem_addr), 32'(TB_DEPTH - 1));
            wr_data = 8'(i + 1);
        end
        wr_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t4_full_noack", 32'(wr_ack), 32'd0);
        end
        check_val("t4_full", 32'(full), 32'd1);
        rd_req = 1'b1;
        step();
        check_val("t4_free_ack",  32'(rd_ack),   32'd1);
        check_val("t4_free_addr", 32'(mem_addr), 32'd0);
        rd_req = 1'b0;
        got = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (wr_ack && !got) begin
                got = 1'b1;
                check_val("t4_refill_addr", 32'(mem_addr), 32'd0);
                check_val("t4_refill_din",  32'(mem_din),  32'h5A);
            end
        end
        check_val("t4_refill_seen", 32'(got), 32'd1);
        wr_req = 1'b0;
        check_val("t4_full_again", 32'(full), 32'd1);

        // read stream across the read-pointer wrap
        rd_req    = 1'b1;
        acks      = 0;
        wrap_seen = 1'b0;
        last_addr = '1;
        exp_prev  = 8'h00;
        for (int j = 0; j < 60; j++) begin
            step();
            if (rd_valid)
                check_val("t5_rd_data", 32'(rd_data), 32'(exp_prev));
            if (rd_ack) begin
                acks++;
                check_val("t5_rd_wrap", 32'(rd_wrap), 32'(mem_addr == ADDR_W'(TB_DEPTH - 1)));
                if (mem_addr == ADDR_W'(TB_DEPTH - 1)) wrap_seen = 1'b1;
                last_addr = mem_addr;
                exp_prev  = (mem_addr == '0) ? 8'h5A : mem_addr[7:0];
            end
        end
        rd_req = 1'b0;
        check_val("t5_ack_cnt",   32'(acks),      32'(TB_DEPTH));
        check_val("t5_wrap_seen", 32'(wrap_seen), 32'd1);
        check_val("t5_last_addr", 32'(last_addr), 32'd0);
        check_val("t5_empty",     32'(empty),     32'd1);

        // reset right behind a read ack squashes the return
        do_reset();
        wr_req  = 1'b1;
        wr_data = 8'h33;
        step(); step();
        wr_req = 1'b0;
        rd_req = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 10 && !got; j++) begin
            step();
            if (rd_ack) got = 1'b1;
        end
        check_val("t6_rd_ack_seen", 32'(got), 32'd1);
        reset  = 1'b1;
        rd_req = 1'b0;
        step();
        check_val("t6_squash0", 32'(rd_valid), 32'd0);
        step();
        check_val("t6_squash1",  32'(rd_valid), 32'd0);
        check_val("t6_empty",    32'(empty),    32'd1);
        check_val("t6_full",     32'(full),     32'd0);
        check_val("t6_addr",     32'(mem_addr), 32'd0);
        check_val("t6_rd_data",  32'(rd_data),  32'd0);
        reset   = 1'b0;
        wr_req  = 1'b1;
        wr_data = 8'h44;
        step();
        check_val("t6_first_ack",  32'(wr_ack),   32'd1);
        check_val("t6_first_addr", 32'(mem_addr), 32'd0);
        wr_req = 1'b0;
        step();

        // enable low blocks all grants and holds pointers
        enable = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        n = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            n += int'(wr_ack) + int'(rd_ack);
        end
        check_val("t6_en_noack", 32'(n),        32'd0);
        check_val("t6_en_empty", 32'(empty),    32'd0);
        check_val("t6_en_addr",  32'(mem_addr), 32'd0);
        enable = 1'b1;
        step();
        check_val("t6_resume_wr",   32'(wr_ack),   32'd1);
        check_val("t6_resume_addr", 32'(mem_addr), 32'd1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
